// File: rtl/clk_mon_pkg.sv
// Shared types, defaults and range helper for the loopback clock monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } clk_mon_state_e;

    localparam int DEF_GATE_CYCLES  = 200000;
    localparam int DEF_EXP_COUNT    = 10000;
    localparam int DEF_TOL          = 16;
    localparam int DEF_LOCK_WINDOWS = 4;
    localparam int DEF_CNT_W        = 24;

    // Inclusive window limit; the lower bound never goes below zero.
    function automatic int clk_mon_limit(input int exp_count, input int tol, input bit upper);
        int lim;
        if (upper) begin
            lim = exp_count + tol;
        end else begin
            lim = (exp_count - tol < 0) ? 0 : exp_count - tol;
        end
        return lim;
    endfunction

endpackage

// File: rtl/clk_loopback_monitor_sync_edge_det.sv
// 2-FF synchronizer plus one edge register; rise_out flags a synchronized rising edge.
// Latency: rise_out asserts in the third cycle after the pin change is captured.
// Backpressure: none, free-running.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_out
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise_out = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/clk_loopback_monitor.sv
// Loopback clock monitor: gated edge count, tolerance check, lock FSM; FREQ_MON_MINMAX_EN adds min/max.
// Latency: window results registered one cycle after the terminal gate cycle.
// Backpressure: none; meas_valid is a single-cycle pulse.
module clk_loopback_monitor
    import clk_mon_pkg::*;
#(
    parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
    parameter int EXP_COUNT    = DEF_EXP_COUNT,
    parameter int TOL          = DEF_TOL,
    parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             toggle_in,
    input  logic             clear_loss,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             in_range,
    output logic             locked,
    output logic             loss_sticky
`ifdef FREQ_MON_MINMAX_EN
    ,
    output logic [CNT_W-1:0] min_count,
    output logic [CNT_W-1:0] max_count
`endif
);

    localparam int TMR_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int GOOD_W   = $clog2(LOCK_WINDOWS + 1);
    localparam int RANGE_LO = clk_mon_limit(EXP_COUNT, TOL, 1'b0);
    localparam int RANGE_HI = clk_mon_limit(EXP_COUNT, TOL, 1'b1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_WINDOWS);

    logic rise;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (toggle_in),
        .rise_out (rise)
    );

    clk_mon_state_e    state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [CNT_W-1:0]  meas_count_q, meas_count_d;
    logic              meas_valid_q, meas_valid_d;
    logic              in_range_q, in_range_d;
    logic              locked_q, locked_d;
    logic              loss_q, loss_d;

    logic [CNT_W-1:0]  win_cnt;
    logic [GOOD_W-1:0] good_inc;
    logic              win_ok;
    logic              loss_set;

    always_comb begin
        // win_cnt folds in an edge seen this cycle, so a terminal-cycle edge lands in the closing window.
        win_cnt  = (rise && edge_cnt_q != CNT_MAX) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
        win_ok   = (win_cnt != CNT_MAX) && (int'(win_cnt) >= RANGE_LO) && (int'(win_cnt) <= RANGE_HI);
        good_inc = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);

        state_d      = state_q;
        timer_d      = timer_q;
        edge_cnt_d   = edge_cnt_q;
        good_d       = good_q;
        meas_count_d = meas_count_q;
        meas_valid_d = 1'b0;
        in_range_d   = in_range_q;
        loss_set     = 1'b0;

        if (!enable) begin
            state_d    = IDLE;
            timer_d    = '0;
            edge_cnt_d = '0;
            good_d     = '0;
            loss_set   = (state_q == LOCKED);
        end else if (state_q == IDLE) begin
            state_d    = ACQ;
            timer_d    = '0;
            edge_cnt_d = '0;
            good_d     = '0;
        end else if (timer_q == TMR_LAST) begin
            timer_d      = '0;
            edge_cnt_d   = '0;
            meas_count_d = win_cnt;
            meas_valid_d = 1'b1;
            in_range_d   = win_ok;
            if (win_ok) begin
                good_d = good_inc;
                if (good_inc == GOOD_MAX) begin
                    state_d = LOCKED;
                end
            end else begin
                good_d   = '0;
                state_d  = ACQ;
                loss_set = (state_q == LOCKED);
            end
        end else begin
            timer_d    = timer_q + TMR_W'(1);
            edge_cnt_d = win_cnt;
        end

        locked_d = (state_d == LOCKED);
        loss_d   = loss_set | (loss_q & ~clear_loss);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            edge_cnt_q   <= '0;
            good_q       <= '0;
            meas_count_q <= '0;
            meas_valid_q <= 1'b0;
            in_range_q   <= 1'b0;
            locked_q     <= 1'b0;
            loss_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            edge_cnt_q   <= edge_cnt_d;
            good_q       <= good_d;
            meas_count_q <= meas_count_d;
            meas_valid_q <= meas_valid_d;
            in_range_q   <= in_range_d;
            locked_q     <= locked_d;
            loss_q       <= loss_d;
        end
    end

    assign meas_count  = meas_count_q;
    assign meas_valid  = meas_valid_q;
    assign in_range    = in_range_q;
    assign locked      = locked_q;
    assign loss_sticky = loss_q;

`ifdef FREQ_MON_MINMAX_EN
    logic [CNT_W-1:0] min_q, min_d, min_base;
    logic [CNT_W-1:0] max_q, max_d, max_base;

    always_comb begin
        min_base = clear_loss ? '1 : min_q;
        max_base = clear_loss ? '0 : max_q;
        min_d    = min_base;
        max_d    = max_base;
        if (meas_valid_d) begin
            if (meas_count_d < min_base) min_d = meas_count_d;
            if (meas_count_d > max_base) max_d = meas_count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_count = min_q;
    assign max_count = max_q;
`endif

endmodule

// File: tb/tb_clk_loopback_monitor.sv
// Directed bench for clk_loopback_monitor with a shortened gate window (40 cycles, expect 10 +/- 2).
// Toggle stimulus is driven per window position; edges surface in the counter two cycles later.
module tb_clk_loopback_monitor;

    localparam int G   = 40;
    localparam int EXP = 10;
    localparam int TL  = 2;
    localparam int LW  = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n, enable, toggle_in, clear_loss;
    logic [CW-1:0] meas_count;
    logic          meas_valid, in_range, locked, loss_sticky;
`ifdef FREQ_MON_MINMAX_EN
    logic [CW-1:0] min_count, max_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    clk_loopback_monitor #(
        .GATE_CYCLES (G),
        .EXP_COUNT   (EXP),
        .TOL         (TL),
        .LOCK_WINDOWS(LW),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .toggle_in  (toggle_in),
        .clear_loss (clear_loss),
        .meas_count (meas_count),
        .meas_valid (meas_valid),
        .in_range   (in_range),
        .locked     (locked),
        .loss_sticky(loss_sticky)
`ifdef FREQ_MON_MINMAX_EN
        ,
        .min_count  (min_count),
        .max_count  (max_count)
`endif
    );

    typedef struct {
        int n;
        bit extra;
        int clr;
        int cnt;
        bit rng;
        bit lock;
        bit loss;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full gate window starting at timer 0; n edges at even positions, optional edge at 37.
    // clr=1 pulses clear_loss mid-window, clr=2 in the terminal cycle.
    task automatic run_win(input int n, input bit extra, input int clr, output int stray);
        stray = 0;
        for (int t = 0; t < G; t++) begin
            @(negedge clk);
            toggle_in  = ((t < 2 * n) && (t % 2 == 0)) || (extra && t == 37);
            clear_loss = (clr == 1 && t == 5) || (clr == 2 && t == G - 1);
            @(posedge clk);
            #1;
            if (t != G - 1 && meas_valid) stray++;
        end
        clear_loss = 1'b0;
    endtask

    task automatic win_checked(input int n, input int cnt, input bit lock, input string tag);
        int stray;
        run_win(n, 1'b0, 0, stray);
        check({tag, "_stray"}, stray, 0);
        check({tag, "_valid"}, meas_valid, 1);
        check({tag, "_cnt"}, meas_count, cnt);
        check({tag, "_lock"}, locked, lock);
    endtask

    initial begin
        int stray;
        int nv;
        int mn, mx;

        tbl[0]  = '{10, 1'b0, 0, 10, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{10, 1'b0, 0, 10, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{10, 1'b0, 0, 10, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{10, 1'b0, 0, 10, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{ 8, 1'b0, 0,  8, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{12, 1'b0, 0, 12, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{13, 1'b0, 0, 13, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{ 7, 1'b0, 1,  7, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{ 8, 1'b0, 0,  8, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{12, 1'b0, 0, 12, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{11, 1'b0, 0, 11, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{20, 1'b0, 0, 15, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{10, 1'b0, 0, 11, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{10, 1'b0, 0, 10, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{10, 1'b0, 0, 10, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{ 9, 1'b1, 0, 10, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{ 0, 1'b0, 2,  0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; enable = 1'b0; toggle_in = 1'b0; clear_loss = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_meas_count", meas_count, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_in_range", in_range, 0);
        check("rst_locked", locked, 0);
        check("rst_loss", loss_sticky, 0);
`ifdef FREQ_MON_MINMAX_EN
        check("rst_min", min_count, 15);
        check("rst_max", max_count, 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) enable = 1'b1;
        @(posedge clk);

        mn = 15; mx = 0;
        for (int i = 0; i < 17; i++) begin
            run_win(tbl[i].n, tbl[i].extra, tbl[i].clr, stray);
            check($sformatf("w%0d_stray", i), stray, 0);
            check($sformatf("w%0d_valid", i), meas_valid, 1);
            check($sformatf("w%0d_cnt", i), meas_count, tbl[i].cnt);
            check($sformatf("w%0d_rng", i), in_range, tbl[i].rng);
            check($sformatf("w%0d_lock", i), locked, tbl[i].lock);
            check($sformatf("w%0d_loss", i), loss_sticky, tbl[i].loss);
`ifdef FREQ_MON_MINMAX_EN
            if (tbl[i].clr != 0) begin mn = 15; mx = 0; end
            if (tbl[i].cnt < mn) mn = tbl[i].cnt;
            if (tbl[i].cnt > mx) mx = tbl[i].cnt;
            check($sformatf("w%0d_min", i), min_count, mn);
            check($sformatf("w%0d_max", i), max_count, mx);
`endif
        end

        // Clear the sticky flag while dropping enable from ACQ (no new loss event).
        @(negedge clk) begin clear_loss = 1'b1; enable = 1'b0; end
        @(posedge clk); #1;
        clear_loss = 1'b0;
        check("clear_loss", loss_sticky, 0);
        @(negedge clk) enable = 1'b1;
        @(posedge clk);

        for (int i = 0; i < LW; i++) win_checked(10, 10, i == LW - 1, $sformatf("relock%0d", i));

        // Abort mid-window while LOCKED.
        for (int t = 0; t < 15; t++) begin
            @(negedge clk) toggle_in = (t % 2 == 0);
            @(posedge clk);
        end
        @(negedge clk) begin enable = 1'b0; toggle_in = 1'b0; end
        @(posedge clk); #1;
        check("abort_locked", locked, 0);
        check("abort_loss", loss_sticky, 1);
        nv = 0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            if (meas_valid) nv++;
        end
        check("abort_no_valid", nv, 0);
        check("abort_cnt_hold", meas_count, 10);
        check("abort_rng_hold", in_range, 1);

        @(negedge clk) enable = 1'b1;
        @(posedge clk);
        win_checked(10, 10, 1'b0, "reen0");
        for (int i = 1; i < LW; i++) win_checked(10, 10, i == LW - 1, $sformatf("reen%0d", i));

        // Asynchronous reset in the middle of a window.
        for (int t = 0; t < 20; t++) begin
            @(negedge clk) toggle_in = (t % 2 == 0);
            @(posedge clk);
        end
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("arst_meas_count", meas_count, 0);
        check("arst_meas_valid", meas_valid, 0);
        check("arst_in_range", in_range, 0);
        check("arst_locked", locked, 0);
        check("arst_loss", loss_sticky, 0);
        toggle_in = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        nv = 0;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk); #1;
            if (meas_valid) nv++;
        end
        check("arst_no_valid", nv, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
